ili9341_frame_scheduler: RTL

//  Sequences full-frame pixel transfers from the VPU to the ILI9341 8-bit parallel bus engine.
//  - On each frame start, sets the address window (CASET, PASET), then issues RAMWR.
//  - Streams buffered VPU pixels as RGB565 byte pairs, high byte first.
//  - Sits between the vpu color/sync outputs and the byte-level LCD bus writer, after LCD init.

---
 rtl/ili9341_pkg.sv | 31 +++
 rtl/ili9341_frame_scheduler_fifo.sv | 69 ++++++
 rtl/ili9341_frame_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ili9341_pkg
// Description : Shared definitions for the ILI9341 frame scheduler.
//               ILI9341 command opcodes, the scheduler state type and the
//               RGB888 -> RGB565 packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ili9341_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;  // column address set
    localparam logic [7:0] CMD_PASET = 8'h2B;  // page (row) address set
    localparam logic [7:0] CMD_RAMWR = 8'h2C;  // memory write

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CASET  = 3'd1,
        PASET  = 3'd2,
        RAMWR  = 3'd3,
        PIX_HI = 3'd4,
        PIX_LO = 3'd5
    } sched_state_t;

    // Input packing is {B[23:16], G[15:8], R[7:0]}; the panel expects
    // {R[7:3], G[7:2], B[7:3]} as one 16-bit word.
    function automatic logic [15:0] rgb888_to_rgb565(input logic [23:0] rgb);
        return {rgb[7:3], rgb[15:10], rgb[23:19]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ili9341_frame_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock pixel FIFO with flush.
//               The head entry is presented on dout straight from the
//               storage registers, so it is valid whenever empty is low.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push, din       - write request / data (ignored when full)
//               pop             - remove head entry (ignored when empty)
//               flush           - discard all contents; wins over push/pop
//               full, empty     - occupancy flags
//               dout            - head entry
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full & ~flush;
    assign w_do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + (c_AW + 1)'(w_do_push) - (c_AW + 1)'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ili9341_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ili9341_frame_scheduler
// Description : Turns a VPU pixel stream into ILI9341 bus bytes. Each frame
//               begins with CASET / PASET window setup and RAMWR, then every
//               buffered pixel is sent as an RGB565 pair, high byte first.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               enable                  - LCD init complete; gates frame start
//               frame_start             - 1-cycle pulse at first pixel
//               pix_valid/pix_color     - pixel input {B,G,R}
//               pix_ready               - FIFO not full
//               bus_valid/dc/data       - byte request to the bus engine
//               bus_ready               - bus engine accepts the byte
//               busy                    - scheduler not idle
//               overflow                - sticky dropped-pixel flag
//               frame_count             - completed frames (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module ili9341_frame_scheduler
    import ili9341_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [23:0] pix_color,
    output logic        pix_ready,
    output logic        bus_valid,
    output logic        bus_dc,
    output logic [7:0]  bus_data,
    input  logic        bus_ready,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  frame_count
);

    localparam logic [15:0] c_COL_END  = 16'(WIDTH - 1);
    localparam logic [15:0] c_ROW_END  = 16'(HEIGHT - 1);
    localparam logic [16:0] c_PIX_LAST = 17'(WIDTH * HEIGHT - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [3:0]   r_idx;
    logic [3:0]   w_idx_nxt;
    logic [16:0]  r_pix_cnt;
    logic [16:0]  w_pix_cnt_nxt;
    logic         w_frame_done;
    logic         r_resync;
    logic         r_overflow;
    logic [7:0]   r_frame_count;

    logic         w_xfer;
    logic         w_boundary;
    logic         w_flush;
    logic         w_fifo_pop;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [23:0]  w_fifo_dout;
    logic [15:0]  w_rgb565;

    logic         w_bus_valid;
    logic         w_bus_dc;
    logic [7:0]   w_bus_data;

    // Window data bytes: start coordinate is always 0, then end high/low.
    function automatic logic [7:0] coord_byte(input logic [3:0] idx,
                                              input logic [15:0] end_val);
        case (idx)
            4'd3:    return end_val[15:8];
            4'd4:    return end_val[7:0];
            default: return 8'h00;
        endcase
    endfunction

    assign w_xfer     = w_bus_valid & bus_ready;
    // Safe point to restart: nothing offered, or the offered byte goes now.
    assign w_boundary = ~w_bus_valid | bus_ready;
    assign w_flush    = r_resync & w_boundary;
    assign w_fifo_pop = (r_state == PIX_LO) & w_xfer;
    assign w_rgb565   = rgb888_to_rgb565(w_fifo_dout);

    sync_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pix_valid),
        .din   (pix_color),
        .pop   (w_fifo_pop),
        .flush (w_flush),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .dout  (w_fifo_dout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pix_cnt_nxt = r_pix_cnt;
        w_frame_done  = 1'b0;
        if (w_flush) begin
            w_state_nxt   = CASET;
            w_idx_nxt     = 4'd0;
            w_pix_cnt_nxt = 17'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_start && enable) begin
                        w_state_nxt   = CASET;
                        w_idx_nxt     = 4'd0;
                        w_pix_cnt_nxt = 17'd0;
                    end
                end
                CASET, PASET: begin
                    if (w_xfer) begin
                        if (r_idx == 4'd4) begin
                            w_state_nxt = (r_state == CASET) ? PASET : RAMWR;
                            w_idx_nxt   = 4'd0;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
                RAMWR: begin
                    if (w_xfer) begin
                        w_state_nxt = PIX_HI;
                    end
                end
                PIX_HI: begin
                    if (w_xfer) begin
                        w_state_nxt = PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (w_xfer) begin
                        if (r_pix_cnt == c_PIX_LAST) begin
                            w_state_nxt   = IDLE;
                            w_pix_cnt_nxt = 17'd0;
                            w_frame_done  = 1'b1;
                        end else begin
                            w_state_nxt   = PIX_HI;
                            w_pix_cnt_nxt = r_pix_cnt + 17'd1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Output decode. All inputs are registered state or the FIFO head,
    // which cannot change while a byte is stalled, so the request holds.
    always_comb begin
        w_bus_valid = 1'b0;
        w_bus_dc    = 1'b0;
        w_bus_data  = 8'h00;
        case (r_state)
            CASET: begin
                w_bus_valid = 1'b1;
                w_bus_dc    = (r_idx != 4'd0);
                w_bus_data  = (r_idx == 4'd0) ? CMD_CASET : coord_byte(r_idx, c_COL_END);
            end
            PASET: begin
                w_bus_valid = 1'b1;
                w_bus_dc    = (r_idx != 4'd0);
                w_bus_data  = (r_idx == 4'd0) ? CMD_PASET : coord_byte(r_idx, c_ROW_END);
            end
            RAMWR: begin
                w_bus_valid = 1'b1;
                w_bus_data  = CMD_RAMWR;
            end
            PIX_HI: begin
                w_bus_valid = ~w_fifo_empty;
                w_bus_dc    = 1'b1;
                w_bus_data  = w_rgb565[15:8];
            end
            PIX_LO: begin
                w_bus_valid = 1'b1;
                w_bus_dc    = 1'b1;
                w_bus_data  = w_rgb565[7:0];
            end
            default: begin
                w_bus_valid = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= 4'd0;
            r_pix_cnt     <= 17'd0;
            r_resync      <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_pix_cnt <= w_pix_cnt_nxt;
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (pix_valid && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
            // A fresh pulse re-arms the flag even on the cycle it is consumed.
            if (frame_start && enable && (r_state != IDLE)) begin
                r_resync <= 1'b1;
            end else if (w_flush) begin
                r_resync <= 1'b0;
            end
        end
    end

    assign pix_ready   = ~w_fifo_full;
    assign bus_valid   = w_bus_valid;
    assign bus_dc      = w_bus_dc;
    assign bus_data    = w_bus_data;
    assign busy        = (r_state != IDLE);
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
